// File: rtl/trace_capture_mon.sv
// Retire-trace consumer: buffers one syn_* record per cycle in a first-word-fall-through FIFO,
// counts cycles and retires, detects HALT, and flags watchdog expiry or FIFO overflow on err.
module trace_capture_mon #(
  parameter int         DEPTH   = 16,
  parameter int         WDOG    = 1024,
  parameter logic [4:0] HALT_OP = 5'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ret_valid,
  input  logic [15:0]   syn_PC,
  input  logic [15:0]   syn_Inst,
  input  logic          syn_RegWrite,
  input  logic [2:0]    syn_WriteRegister,
  input  logic [15:0]   syn_WriteData,
  input  logic          syn_MemRead,
  input  logic          syn_MemWrite,
  input  logic [15:0]   syn_MemAddress,
  input  logic [15:0]   syn_MemDataIn,
  input  logic [15:0]   syn_MemDataOut,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [117:0]  rec_data,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   inst_cnt,
  output logic          halted,
  output logic          overflow,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 102;
  localparam int WW = $clog2(WDOG);

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_ERROR} state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [WW-1:0]   wdog_reg;
  logic [31:0]     cyc_reg, inst_reg;
  logic            halted_reg, overflow_reg, err_reg;

  logic            running, sample, empty, full, pop, push, drop, is_halt, wdog_expire;
  logic [RW-1:0]   rec_in;

  assign rec_in = {syn_PC, syn_Inst, syn_RegWrite, syn_WriteRegister, syn_WriteData,
                   syn_MemRead, syn_MemWrite, syn_MemAddress, syn_MemDataIn, syn_MemDataOut};

  assign running     = (state_reg == ST_RUN);
  assign sample      = running && ret_valid;
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop         = !empty && rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push        = sample && (!full || pop);
  assign drop        = sample && full && !pop;
  assign is_halt     = push && (syn_Inst[15:11] == HALT_OP);
  assign wdog_expire = running && !ret_valid && (wdog_reg == WW'(WDOG - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (is_halt)                   state_next = ST_HALTED;
        else if (drop || wdog_expire)  state_next = ST_ERROR;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wdog_reg     <= '0;
      cyc_reg      <= '0;
      inst_reg     <= '0;
      halted_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (running) wdog_reg <= ret_valid ? '0 : wdog_reg + WW'(1);
      if (running && cyc_reg != 32'hFFFF_FFFF) cyc_reg <= cyc_reg + 32'd1;
      if (push && inst_reg != 32'hFFFF_FFFF)   inst_reg <= inst_reg + 32'd1;
      halted_reg   <= (state_next == ST_HALTED);
      err_reg      <= (state_next == ST_ERROR);
      overflow_reg <= overflow_reg | drop;
    end
  end

  // The top 16 bits of the record port carry no field and read as zero.
  assign rec_valid = !empty;
  assign rec_data  = empty ? '0 : {16'h0000, mem[rd_ptr_reg[AW-1:0]]};
  assign cyc_cnt   = cyc_reg;
  assign inst_cnt  = inst_reg;
  assign halted    = halted_reg;
  assign overflow  = overflow_reg;
  assign err       = err_reg;

endmodule
